multicycle_control_fsm: RTL

- Sequencer for the multi-cycle processor datapath. Drives the shared instruction/data memory port, ALU operand muxes, PC/IR enables and register-file write controls, one step per clock.
- Instructions supported: R-type, LW, SW, BEQ, ADDI and J.
- Memory accesses use a req/ready handshake with a bounded wait. Illegal opcodes and memory timeouts trap into a sticky fault state.

---
 rtl/multicycle_control_fsm.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle datapath: one step per clock,
// with a bounded memory handshake and a sticky fault trap.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [3:0] State,
    output logic       Fault,
    output logic [1:0] FaultCode
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        RTEX   = 4'd7,
        ALUWB  = 4'd8,
        BEQEX  = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JEX    = 4'd12,
        FAULT  = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] FC_ILL = 2'b01;
    localparam logic [1:0] FC_TMO = 2'b10;

    localparam bit         TO_EN = (MEM_TIMEOUT != 0);
    localparam logic [7:0] LIM   = 8'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] wcnt;
    logic [1:0] fcode;
    logic [1:0] fcode_nx;
    logic       memst;
    logic       timeout;

    assign memst   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    // A ready on the boundary cycle takes priority over the timeout.
    assign timeout = TO_EN && memst && !MemReady && (wcnt == LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= 8'd0;
            fcode <= 2'b00;
        end else begin
            state <= state_nx;
            fcode <= fcode_nx;
            if (state_nx != state)
                wcnt <= 8'd0;
            else if (memst && !MemReady && wcnt != 8'hff)
                wcnt <= wcnt + 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        fcode_nx = fcode;
        MemReq   = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        PCSrc    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;

        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                MemReq  = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_nx = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                unique case (1'b1)
                    (Op == OP_R):                  state_nx = RTEX;
                    (Op == OP_LW) || (Op == OP_SW): state_nx = MEMADR;
                    (Op == OP_BEQ):                state_nx = BEQEX;
                    (Op == OP_ADDI):               state_nx = ADDIEX;
                    (Op == OP_J):                  state_nx = JEX;
                    default: begin
                        state_nx = FAULT;
                        fcode_nx = FC_ILL;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                state_nx = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                if (MemReady) state_nx = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_nx = FETCH;
            end
            MEMWR: begin
                MemReq   = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) state_nx = FETCH;
            end
            RTEX: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b10;
                state_nx = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_nx = FETCH;
            end
            BEQEX: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                Branch   = 1'b1;
                PCSrc    = 2'b01;
                state_nx = FETCH;
            end
            ADDIEX: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                state_nx = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                state_nx = FETCH;
            end
            JEX: begin
                PCWrite  = 1'b1;
                PCSrc    = 2'b10;
                state_nx = FETCH;
            end
            FAULT: state_nx = FAULT;
            default: begin
                state_nx = FAULT;
                fcode_nx = FC_ILL;
            end
        endcase

        if (timeout) begin
            state_nx = FAULT;
            fcode_nx = FC_TMO;
        end
    end

    assign State     = state;
    assign Fault     = (state == FAULT);
    assign FaultCode = fcode;

endmodule
